// File: rtl/seq_edge_8b_max_switch_gen_pkg.sv
// Shared types and constants for the max-switching burst generator and its benches.
package seq_edge_8b_max_switch_gen_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

   localparam logic [7:0] PAT_A = 8'h55;
   localparam logic [7:0] PAT_B = 8'hAA;
   localparam int         CNT_W = 6;

   // len=0 means a full 32-word burst, hence the extra counter bit
   function automatic logic [CNT_W-1:0] len_to_cnt(input logic [4:0] len);
      return (len == 5'd0) ? 6'd32 : {1'b0, len};
   endfunction
endpackage

// File: rtl/seq_edge_8b_max_switch_gen_if.sv
// Request/response bundle of the burst generator; master drives requests, slave is the generator.
interface seq_edge_8b_max_switch_gen_if;
   logic       start;
   logic [4:0] len;
   logic       first;
   logic       stall;
   logic [7:0] out_;
   logic       out_val;
   logic       busy;
   logic       done;

   modport master (output start, len, first, stall,
                   input  out_, out_val, busy, done);
   modport slave  (input  start, len, first, stall,
                   output out_, out_val, busy, done);
endinterface

// File: rtl/seq_edge_8b_max_switch_gen.sv
// Emits bursts of alternating 55/AA words (every bit toggles each word) with back-pressure.
module seq_edge_8b_max_switch_gen
   import seq_edge_8b_max_switch_gen_pkg::*;
#(
   parameter logic [7:0] IDLE_WORD = 8'h00
) (
   input  logic                         clk,
   input  logic                         reset,
   seq_edge_8b_max_switch_gen_if.slave  bus
);

   state_e           state_q, state_d;
   logic [7:0]       out_q, out_d;
   logic             out_val_q, out_val_d;
   logic [CNT_W-1:0] rem_q, rem_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         out_q     <= IDLE_WORD;
         out_val_q <= 1'b0;
         rem_q     <= '0;
      end else begin
         state_q   <= state_d;
         out_q     <= out_d;
         out_val_q <= out_val_d;
         rem_q     <= rem_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      out_d     = out_q;
      out_val_d = out_val_q;
      rem_d     = rem_q;
      unique case (state_q)
         IDLE: begin
            out_d     = IDLE_WORD;
            out_val_d = 1'b0;
            if (bus.start) begin
               state_d   = RUN;
               out_d     = bus.first ? PAT_B : PAT_A;
               out_val_d = 1'b1;
               rem_d     = len_to_cnt(bus.len);
            end
         end
         RUN: begin
            // stall freezes word, valid and count together
            if (!bus.stall) begin
               if (rem_q == 6'd1) begin
                  state_d   = DONE;
                  out_d     = IDLE_WORD;
                  out_val_d = 1'b0;
                  rem_d     = '0;
               end else begin
                  rem_d = rem_q - 6'd1;
                  out_d = ~out_q;
               end
            end
         end
         DONE: begin
            state_d   = IDLE;
            out_d     = IDLE_WORD;
            out_val_d = 1'b0;
         end
         default: begin
            state_d   = IDLE;
            out_d     = IDLE_WORD;
            out_val_d = 1'b0;
            rem_d     = '0;
         end
      endcase
   end

   assign bus.out_    = out_q;
   assign bus.out_val = out_val_q;
   assign bus.busy    = (state_q != IDLE);
   assign bus.done    = (state_q == DONE);

endmodule

// File: doc/seq_edge_8b_max_switch_gen.md
SEQ_EDGE_8B_MAX_SWITCH_GEN -- requirements
Module: seq_edge_8b_max_switch_gen

Interface
REQ-001: Parameter IDLE_WORD, default 8'h00, SHALL be the word driven on out_ when no burst is active.
REQ-002: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003: reset  input  1  SHALL be asynchronous and active-low; 0 forces the reset state immediately, independent of clk.
REQ-004: start  input  1  SHALL request a burst; sampled only in IDLE.
REQ-005: len  input  5  SHALL give the burst length in words, sampled with start; 0 encodes 32.
REQ-006: first  input  1  SHALL select the first burst word, sampled with start: 0 -> 8'h55, 1 -> 8'hAA.
REQ-007: stall  input  1  SHALL be downstream back-pressure; 1 holds all RUN state for that cycle.
REQ-008: out_  output  8  SHALL be the generated word, registered.
REQ-009: out_val  output  1  SHALL be 1 exactly when out_ carries a burst word.
REQ-010: busy  output  1  SHALL be 1 in RUN and DONE.
REQ-011: done  output  1  SHALL pulse 1 for exactly one cycle after a burst's last word is consumed.

Function
REQ-012: FSM SHALL have three states: IDLE, RUN, DONE.
REQ-013: IDLE: out_=IDLE_WORD, out_val=0, done=0; start=1 at an edge -> RUN, with out_ set to the first word and remaining count set to len (32 if len=0) at that edge.
REQ-014: Start-to-first-word latency SHALL be one edge: the word is visible in the cycle after start is sampled.
REQ-015: RUN with stall=0 SHALL consume the current word at the edge: if remaining=1 -> DONE; otherwise remaining decrements and out_ becomes ~out_ (8'h55 <-> 8'hAA).
REQ-016: RUN with stall=1 SHALL hold out_, out_val, and remaining unchanged; stall SHALL have no effect outside RUN.
REQ-017: A burst of N words SHALL emit exactly N alternating words, giving N-1 consecutive max-switching transitions on out_.
REQ-018: DONE SHALL drive out_=IDLE_WORD, out_val=0, done=1 for one cycle, then -> IDLE unconditionally.
REQ-019: start while busy=1, including in DONE, SHALL be ignored and not queued.
REQ-020: Back-to-back bursts SHALL be separated by at least one DONE cycle and one IDLE sampling cycle.
REQ-021: The remaining counter SHALL be 6 bits so 32 is representable; len=1 SHALL emit one word, then DONE.

Reset
REQ-022: Asserting reset SHALL immediately force state=IDLE, out_=IDLE_WORD, out_val=0, busy=0, done=0, remaining=0.
REQ-023: Reset asserted mid-burst SHALL abort the burst with no done pulse; after deassertion the block SHALL start in IDLE.
REQ-024: After deassertion, the first edge with start=1 SHALL begin a burst normally.

Structure
REQ-025: A shared package SHALL hold the state enum (IDLE, RUN, DONE) and constants PAT_A=8'h55 and PAT_B=8'hAA, for reuse by the max-switching detector benches.
REQ-026: Implementation SHALL be a single module with no sub-modules; the down-counter is inline.

Verification
REQ-027: reset low, then start=1, len=4, first=0, no stall -> out_ 55,AA,55,AA with out_val=1, then done=1 with out_=00, then IDLE.
REQ-028: start=1, len=3, first=1, stall=1 on the 2nd RUN cycle -> out_ AA,55,55,AA; out_val held; done 1 cycle after the last AA.
REQ-029: start=1, len=0 -> exactly 32 alternating words, then one done pulse; output fed to the max-switch detector gives 31 asserted cycles.
REQ-030: start=1 held high through RUN and DONE -> no restart until IDLE; next burst begins the cycle after IDLE samples start.
REQ-031: reset asserted asynchronously mid-clock during the 2nd word of a len=5 burst -> outputs reset immediately, no done pulse, busy=0.
REQ-032: len=1, first=1 -> single AA word, then done; IDLE_WORD overridden to 8'hFF shows FF in IDLE and DONE.
